ble_packet_uart_reporter: RTL and testbench
===========================================

# ble_packet_uart_reporter

Downstream consumer of the packet sniffer's outputs. On each new detected BLE packet it captures the packet bits and length, then serialises a framed report over a single UART TX line (8N1, LSB first) to a host. The frame is sync byte, 16-bit bit-length, payload bytes, then XOR checksum. Packets detected while a frame is in flight are dropped and counted.

## Interface
- PACKET_LEN_MAX, 376: maximum on-air packet length in bits, preamble included.
- PREAMBLE_LEN, 8: preamble bits stripped by the sniffer; payload width W = PACKET_LEN_MAX-PREAMBLE_LEN (368).
- CLKS_PER_BIT, 139: clk cycles per UART bit (16 MHz / 115200).
- SYNC_BYTE, 8'hA5: first byte of every frame.

- clk  in  1  16 MHz system clock; only clock.
- rst  in  1  asynchronous, active-high reset.
- packet_detected  in  1  sniffer detect flag, synchronous to clk, held ≥1 cycle.
- packet_out  in  W  captured packet bits; bit 0 = first bit received after preamble.
- packet_len  in  9  packet length in bits (payload bits valid in packet_out).
- tx  out  1  UART serial output, idle high.
- busy  out  1  high while a frame is being captured or sent.
- frame_done  out  1  one-cycle pulse at end of last stop bit.
- drop_count  out  8  saturating count of packets ignored while busy.

## Operation
- Rising-edge detect on packet_detected (registered copy). Edge with busy=0 → capture; edge with busy=1 → drop_count+1, saturating at 255; no capture.
- Capture latches packet_out and L = min(packet_len, W). Bits of the latched vector at index ≥ L are zeroed. N = ceil(L/8) payload bytes (0..46).
- Frame byte order: SYNC_BYTE, {7'b0, L[8]}, L[7:0], payload byte 0..N-1 (byte k = bits [8k+7:8k]), checksum = XOR of all bytes after SYNC_BYTE.
- Byte FSM: IDLE → SYNC → LEN_HI → LEN_LO → PAYLOAD (N bytes, skipped when N=0) → CSUM → IDLE.
- Bit FSM per byte: START (tx=0) → DATA (8 bits, bit 0 first) → STOP (tx=1) → next byte or IDLE. Each state/bit lasts exactly CLKS_PER_BIT cycles.
- Checksum accumulates as each byte is loaded into the shift register.
- Reset, at any time including mid-frame: tx=1, busy=0, frame_done=0, drop_count=0, FSMs to IDLE, edge register cleared; the partial frame is abandoned.
- packet_detected held high across many cycles produces one capture only; it must go low and rise again to start another.

## Timing
- Cycle E: packet_detected first sampled high. E+1: capture, busy rises. E+2: tx falls (start bit of SYNC).
- Bytes are back-to-back with no idle gap; frame length = (N+4)×10×CLKS_PER_BIT cycles from tx fall.
- frame_done pulses on the final cycle of the checksum stop bit; busy falls the next cycle. An edge arriving on that frame_done cycle is dropped; an edge on the following cycle is accepted.
- An edge and frame_done in the same cycle: count drop, still end frame normally.
- Outputs registered; tx glitch-free.

## Test plan
- CLKS_PER_BIT=4, packet_len=16, packet_out[15:0]=16'h3C5A → UART bytes A5 00 10 5A 3C, checksum 00^10^5A^3C=76; busy high E+1 until frame_done; frame 60 bits = 240 cycles.
- packet_len=0 → bytes A5 00 00 00; frame_done after 160 cycles (CLKS_PER_BIT=4).
- packet_len=300, ones in all bits → L[8]=1, bytes A5 01 2C, 38 payload bytes with last byte 0x0F, XOR checksum matches model; packet_len=400 → clamped to 368 (01 70), 46 payload bytes.
- Three pulses during a frame, then 300 more with drop_count preloaded via repeats → drop_count=3, then saturates at 255; frame content unaffected.
- Assert rst mid-DATA of payload byte 2 → tx=1, busy=0 same cycle (async); next packet_detected edge after release gives a complete fresh frame.
- packet_detected held high 1000 cycles → exactly one frame, drop_count=0; pulse one cycle after busy falls → accepted.

Source files
------------

// File: rtl/ble_packet_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module      : ble_packet_uart_reporter
// Description : Captures each newly detected BLE packet and sends it to a host
//               as a framed 8N1 UART report: sync byte, 16-bit bit length,
//               payload bytes (LSB first) and an XOR checksum. Packets that
//               arrive while a frame is in flight are dropped and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module ble_packet_uart_reporter #(
    parameter int         PACKET_LEN_MAX = 376,
    parameter int         PREAMBLE_LEN   = 8,
    parameter int         CLKS_PER_BIT   = 139,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   packet_detected,
    input  logic [PACKET_LEN_MAX-PREAMBLE_LEN-1:0] packet_out,
    input  logic [8:0]                             packet_len,
    output logic                                   tx,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic [7:0]                             drop_count
);

    localparam int c_W     = PACKET_LEN_MAX - PREAMBLE_LEN;
    localparam int c_CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        B_IDLE    = 3'd0,
        B_SYNC    = 3'd1,
        B_LEN_HI  = 3'd2,
        B_LEN_LO  = 3'd3,
        B_PAYLOAD = 3'd4,
        B_CSUM    = 3'd5
    } byte_state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_DATA  = 2'd2,
        T_STOP  = 2'd3
    } bit_state_t;

    byte_state_t r_byte_state, w_byte_next, w_succ;
    bit_state_t  r_bit_state,  w_bit_next;

    logic               r_pd_s, r_pd_d;
    logic [c_W-1:0]     r_payload;
    logic [8:0]         r_len;
    logic [5:0]         r_bytes_left;
    logic [7:0]         r_shift;
    logic [7:0]         r_csum;
    logic [2:0]         r_bit_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_tx, r_busy, r_frame_done;
    logic [7:0]         r_drop;

    logic               w_edge, w_capture, w_drop, w_bit_end;
    logic               w_load, w_finish, w_done;
    logic [7:0]         w_load_byte;
    logic [8:0]         w_len;
    logic [5:0]         w_nbytes;
    logic [c_W-1:0]     w_mask;

    assign w_edge    = r_pd_s & ~r_pd_d;
    assign w_bit_end = (r_cnt == c_CNT_W'(CLKS_PER_BIT - 1));

    // Clamp the reported length, build the keep-mask and round up to bytes
    always_comb begin
        w_len = (packet_len > 9'(c_W)) ? 9'(c_W) : packet_len;
        for (int i = 0; i < c_W; i++) begin
            w_mask[i] = (i < int'(w_len));
        end
        w_nbytes = w_len[8:3] + {5'b0, |w_len[2:0]};
    end

    // Byte and bit state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_state <= B_IDLE;
            r_bit_state  <= T_IDLE;
        end else begin
            r_byte_state <= w_byte_next;
            r_bit_state  <= w_bit_next;
        end
    end

    // Next-state logic: byte sequencing and bit timing, plus load/finish strobes
    always_comb begin
        w_byte_next = r_byte_state;
        w_bit_next  = r_bit_state;
        w_succ      = B_IDLE;
        w_load      = 1'b0;
        w_finish    = 1'b0;
        w_done      = 1'b0;
        w_load_byte = 8'h00;
        w_capture   = w_edge & ~r_busy;
        w_drop      = w_edge & r_busy;

        // Byte that follows the current one once its stop bit ends
        case (r_byte_state)
            B_SYNC:              w_succ = B_LEN_HI;
            B_LEN_HI:            w_succ = B_LEN_LO;
            B_LEN_LO, B_PAYLOAD: w_succ = (r_bytes_left == 6'd0) ? B_CSUM : B_PAYLOAD;
            default:             w_succ = B_IDLE;
        endcase

        case (r_bit_state)
            T_IDLE: begin
                if (r_byte_state == B_IDLE) begin
                    if (w_capture) begin
                        w_byte_next = B_SYNC;
                    end
                end else begin
                    // One cycle after capture the sync byte enters the shifter
                    w_load     = 1'b1;
                    w_bit_next = T_START;
                end
            end
            T_START: begin
                if (w_bit_end) begin
                    w_bit_next = T_DATA;
                end
            end
            T_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) begin
                    w_bit_next = T_STOP;
                end
            end
            T_STOP: begin
                // Registered pulse lands on the last cycle of the final stop bit
                if ((r_byte_state == B_CSUM) && (r_cnt == c_CNT_W'(CLKS_PER_BIT - 2))) begin
                    w_done = 1'b1;
                end
                if (w_bit_end) begin
                    if (r_byte_state == B_CSUM) begin
                        w_byte_next = B_IDLE;
                        w_bit_next  = T_IDLE;
                        w_finish    = 1'b1;
                    end else begin
                        w_byte_next = w_succ;
                        w_bit_next  = T_START;
                        w_load      = 1'b1;
                    end
                end
            end
            default: w_bit_next = T_IDLE;
        endcase

        case (w_byte_next)
            B_SYNC:    w_load_byte = SYNC_BYTE;
            B_LEN_HI:  w_load_byte = {7'b0, r_len[8]};
            B_LEN_LO:  w_load_byte = r_len[7:0];
            B_PAYLOAD: w_load_byte = r_payload[7:0];
            B_CSUM:    w_load_byte = r_csum;
            default:   w_load_byte = 8'h00;
        endcase
    end

    // Datapath: edge detect, capture, drop counter, shifter, checksum, outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pd_s       <= 1'b0;
            r_pd_d       <= 1'b0;
            r_payload    <= '0;
            r_len        <= 9'd0;
            r_bytes_left <= 6'd0;
            r_shift      <= 8'h00;
            r_csum       <= 8'h00;
            r_bit_idx    <= 3'd0;
            r_cnt        <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_drop       <= 8'h00;
        end else begin
            r_pd_s       <= packet_detected;
            r_pd_d       <= r_pd_s;
            r_frame_done <= w_done;

            if (w_drop && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end

            if (w_capture) begin
                r_payload    <= packet_out & w_mask;
                r_len        <= w_len;
                r_bytes_left <= w_nbytes;
                r_csum       <= 8'h00;
                r_busy       <= 1'b1;
            end
            if (w_finish) begin
                r_busy <= 1'b0;
            end

            if (w_load || (r_bit_state == T_IDLE) || w_bit_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (w_load) begin
                r_shift   <= w_load_byte;
                r_tx      <= 1'b0;
                r_bit_idx <= 3'd0;
                if (w_byte_next == B_PAYLOAD) begin
                    r_payload    <= r_payload >> 8;
                    r_bytes_left <= r_bytes_left - 6'd1;
                end
                if ((w_byte_next == B_LEN_HI) || (w_byte_next == B_LEN_LO) ||
                    (w_byte_next == B_PAYLOAD)) begin
                    r_csum <= r_csum ^ w_load_byte;
                end
            end else if (w_bit_end) begin
                case (r_bit_state)
                    T_START: begin
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                    T_DATA: begin
                        if (r_bit_idx == 3'd7) begin
                            r_tx <= 1'b1;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                    default: r_tx <= 1'b1;
                endcase
            end
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign drop_count = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_ble_packet_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ble_packet_uart_reporter
// Description : Randomised scoreboard bench for ble_packet_uart_reporter.
//               A reference model turns each issued packet into the expected
//               byte list; a UART receiver process decodes tx and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ble_packet_uart_reporter;

    localparam int CPB = 4;
    localparam int W   = 368;

    logic         clk;
    logic         rst;
    logic         packet_detected;
    logic [W-1:0] packet_out;
    logic [8:0]   packet_len;
    logic         tx;
    logic         busy;
    logic         frame_done;
    logic [7:0]   drop_count;

    logic [7:0]   exp_q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           exp_drop = 0;
    logic         rx_abort = 1'b0;

    ble_packet_uart_reporter #(
        .PACKET_LEN_MAX(376),
        .PREAMBLE_LEN  (8),
        .CLKS_PER_BIT  (CPB),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .packet_detected(packet_detected),
        .packet_out     (packet_out),
        .packet_len     (packet_len),
        .tx             (tx),
        .busy           (busy),
        .frame_done     (frame_done),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge rst) rx_abort = 1'b1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd_data();
        logic [383:0] v;
        for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
        return v[W-1:0];
    endfunction

    // Reference model: frame bytes straight from the report format rules
    task automatic push_model(input int len, input logic [W-1:0] data, output int f);
        int L;
        int n;
        logic [7:0] b;
        logic [7:0] cs;
        L  = (len > W) ? W : len;
        n  = (L + 7) / 8;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(L / 256));
        exp_q.push_back(8'(L % 256));
        cs = 8'(L / 256) ^ 8'(L % 256);
        for (int k = 0; k < n; k++) begin
            b = 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (8 * k + j < L) b[j] = data[8 * k + j];
            end
            exp_q.push_back(b);
            cs = cs ^ b;
        end
        exp_q.push_back(cs);
        f = (n + 4) * 10 * CPB;
    endtask

    // Drive a new packet on the current falling edge and record its frame
    task automatic issue(input int len, input logic [W-1:0] data, output int f);
        packet_len      = 9'(len);
        packet_out      = data;
        packet_detected = 1'b1;
        push_model(len, data, f);
    endtask

    // Entered at the falling edge of cycle E; returns in the frame_done cycle
    task automatic run_frame(input int f, input bit rel, input int poke);
        int cnt;
        int lows;
        chk("busy_at_E", busy, 1'b0);
        if (rel) packet_detected = 1'b0;
        @(negedge clk);
        chk("busy_E1", {busy, tx}, 2'b11);
        @(negedge clk);
        chk("tx_fall_E2", tx, 1'b0);
        cnt  = 0;
        lows = 0;
        while (cnt < f + 50) begin
            if (cnt == poke) packet_detected = 1'b1;
            else if (cnt == poke + 1) packet_detected = 1'b0;
            if (frame_done) break;
            if (!busy) lows++;
            @(negedge clk);
            cnt++;
        end
        chk("frame_done_cycle", cnt, f - 1);
        chk("busy_through_frame", lows, 0);
    endtask

    task automatic do_packet(input int len, input logic [W-1:0] data);
        int f;
        issue(len, data, f);
        @(negedge clk);
        run_frame(f, 1'b1, -1);
        @(negedge clk);
        chk("idle_after", {busy, frame_done, tx}, 3'b001);
        chk("drop_unchanged", drop_count, exp_drop);
    endtask

    // UART receiver: samples mid-bit and checks each byte against the queue
    initial begin
        logic [7:0] b;
        logic       sb, pb;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                rx_abort = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CPB) @(negedge clk);
                pb = tx;
                if (!rx_abort) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_byte: got %0h expected none", b);
                    end else begin
                        chk("rx_byte", {sb, pb, b}, {1'b0, 1'b1, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        logic [W-1:0] d;
        int f, f2;

        rst = 1'b1;
        packet_detected = 1'b0;
        packet_out = '0;
        packet_len = 9'd0;
        repeat (3) @(negedge clk);
        chk("reset_state", {tx, busy, frame_done, drop_count}, {3'b100, 8'h00});
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frames
        d = '0;
        d[15:0] = 16'h3C5A;
        do_packet(16, d);
        do_packet(0, rnd_data());
        d = '1;
        do_packet(300, d);
        do_packet(400, rnd_data());

        // Level held for 1000 cycles yields one frame only
        issue(16, rnd_data(), f);
        @(negedge clk);
        run_frame(f, 1'b0, -1);
        repeat (1000 - f - 3) @(negedge clk);
        packet_detected = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_single_frame", {busy, drop_count}, {1'b0, 8'h00});

        // Random packets
        for (int r = 0; r < 4; r++) begin
            do_packet(int'($urandom_range(0, 400)), rnd_data());
        end

        // Edge during the frame_done cycle is dropped
        issue(8, rnd_data(), f);
        @(negedge clk);
        run_frame(f, 1'b1, f - 2);
        exp_drop++;
        repeat (4) @(negedge clk);
        chk("edge_on_done_dropped", {busy, drop_count}, {1'b0, 8'(exp_drop)});

        // Edge one cycle later is accepted
        d = rnd_data();
        issue(24, d, f);
        push_model(24, d, f2);
        @(negedge clk);
        run_frame(f, 1'b1, f - 1);
        @(negedge clk);
        run_frame(f2, 1'b1, -1);
        @(negedge clk);
        chk("idle_after_back_to_back", busy, 1'b0);

        // Asynchronous reset in the middle of payload byte 2
        issue(64, rnd_data(), f);
        @(negedge clk);
        packet_detected = 1'b0;
        repeat (2) @(negedge clk);
        chk("tx_fall_before_reset", tx, 1'b0);
        repeat (5 * 10 * CPB + CPB + 3 * CPB) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_reset", {tx, busy, frame_done, drop_count}, {3'b100, 8'h00});
        exp_q.delete();
        exp_drop = 0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        do_packet(40, rnd_data());

        // Three drops inside one frame
        issue(64, rnd_data(), f);
        @(negedge clk);
        fork
            run_frame(f, 1'b1, -1);
            begin
                repeat (10) @(negedge clk);
                repeat (3) begin
                    packet_detected = 1'b1;
                    @(negedge clk);
                    packet_detected = 1'b0;
                    @(negedge clk);
                    if (exp_drop < 255) exp_drop++;
                end
            end
        join
        @(negedge clk);
        chk("drop_three", drop_count, exp_drop);

        // 300 more drops saturate the counter
        issue(368, rnd_data(), f);
        @(negedge clk);
        fork
            run_frame(f, 1'b1, -1);
            begin
                repeat (10) @(negedge clk);
                repeat (300) begin
                    packet_detected = 1'b1;
                    @(negedge clk);
                    packet_detected = 1'b0;
                    @(negedge clk);
                    if (exp_drop < 255) exp_drop++;
                end
            end
        join
        @(negedge clk);
        chk("drop_saturate", drop_count, exp_drop);

        repeat (20) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
